tx_resp_fifo: RTL and testbench
===============================

# tx_resp_fifo

Single-clock response buffer in the REF_CLK domain. It sits between the system controller's transmit outputs and the TX data synchronizer that feeds the UART transmitter. It queues response bytes, including 16-bit ALU results split into two bytes, and releases them one at a time. Each byte goes out as a one-cycle valid pulse, paced by the synchronized UART busy flag, so back-to-back responses are never dropped while the UART is still shifting.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width.
- DEPTH, 8, number of entries; must be a power of two and at least 4.
- ADDR_W, 3, log2(DEPTH).
- BUSY_TIMEOUT, 255, maximum number of cycles to wait for Busy to rise after a send.

Ports:
- CLK  in  1  REF domain clock (scan-muxed upstream).
- RST  in  1  reset; synchronous, active-high.
- WR_EN  in  1  push WR_DATA (one byte).
- WR_DATA  in  DATA_WIDTH  byte to push.
- WR16_EN  in  1  push WR16_DATA as two entries: low byte first, then high byte.
- WR16_DATA  in  2*DATA_WIDTH  ALU result.
- Busy  in  1  UART TX busy flag, already synchronized to CLK.
- TX_P_DATA  out  DATA_WIDTH  byte to the TX data synchronizer; registered.
- TX_D_VLD  out  1  one-cycle send pulse.
- COUNT  out  ADDR_W+1  number of occupied entries.
- EMPTY  out  1  COUNT==0.
- FULL  out  1  COUNT==DEPTH.
- OVERFLOW  out  1  sticky; set when a write is dropped.
- TX_TIMEOUT  out  1  sticky; set when Busy never rose after a send.

## Operation
Reset values:
- RST high at a CLK edge clears the pointers, COUNT, TX_P_DATA, TX_D_VLD, OVERFLOW and TX_TIMEOUT; sets EMPTY=1; places the FSM in IDLE.
- Reset mid-send discards all entries. TX_D_VLD is 0 in the cycle after the reset edge.

Storage and write rules:
- Circular buffer; read and write pointers wrap modulo DEPTH.
- Write admission uses COUNT *before* any same-cycle pop. A pop in the same cycle does not create room for a write.
- WR_EN: accepted if COUNT ≤ DEPTH-1.
- WR16_EN: accepted only if COUNT ≤ DEPTH-2. Both bytes are written atomically in one cycle. It is never partially written.
- WR16_EN and WR_EN asserted together: WR16_EN takes priority, the byte write is dropped, and OVERFLOW is set.
- Any rejected write sets OVERFLOW. OVERFLOW clears only on RST.
- COUNT next = COUNT + writes (0, 1 or 2) − pop (0 or 1).

FSM states:
- IDLE: when !EMPTY and !Busy, pop the head entry into TX_P_DATA, assert TX_D_VLD for one cycle, clear the timer, go to WAIT_HI.
- WAIT_HI: when Busy=1, go to WAIT_LO. If the timer reaches BUSY_TIMEOUT, set TX_TIMEOUT and go to IDLE.
- WAIT_LO: when Busy=0, go to IDLE.

Output behaviour:
- TX_P_DATA holds the last popped byte until the next pop.
- No pop occurs in WAIT_HI or WAIT_LO.

## Timing
- Latency, empty FIFO in IDLE with Busy=0: a byte written at edge k is visible at edge k. It is popped at edge k+1, so TX_D_VLD is high for the cycle after the write cycle.
- TX_D_VLD is never high on two consecutive cycles.
- Minimum spacing between pulses is 3 cycles when Busy rises and falls immediately.
- A byte written while the FSM is in WAIT_HI or WAIT_LO is not sent before the FSM returns to IDLE.
- The timer counts cycles spent in WAIT_HI, saturating at BUSY_TIMEOUT. The timeout exit occurs exactly BUSY_TIMEOUT cycles after entering WAIT_HI.
- COUNT, EMPTY and FULL are registered and reflect the state after the edge.

## Test plan
- Reset: hold RST for 2 cycles with WR_EN=1 → COUNT=0, EMPTY=1, TX_D_VLD=0, OVERFLOW=0.
- Single byte: write 0xA5, then Busy rises 3 cycles after TX_D_VLD and falls 20 cycles later → exactly one TX_D_VLD pulse, TX_P_DATA=0xA5, COUNT returns to 0.
- 16-bit ordering: WR16_DATA=0x1234 → pulses carry 0x34 then 0x12. The second pulse occurs only after Busy has risen and fallen.
- Full and wrap: with Busy held high, write 8 bytes 0x00..0x07, then a 9th byte 0xFF → FULL=1 and OVERFLOW=1. Release Busy and cycle it per byte → output 0x00..0x07 in order. Then write 12 more bytes in batches → order preserved across the pointer wrap.
- WR16 corner: with COUNT=7, assert WR16_EN → rejected, COUNT stays 7, OVERFLOW=1. With WR_EN and WR16_EN together on an empty FIFO → COUNT=2, OVERFLOW=1.
- Timeout and mid-send reset: hold Busy=0 after a send → TX_TIMEOUT=1 after 255 cycles and the FSM returns to IDLE. Assert RST while in WAIT_LO with 3 entries queued → COUNT=0 and no further pulses.

Source files
------------

// File: rtl/tx_resp_fifo_if.sv
// Handshake bundle between the system controller, the response FIFO and the
// TX data synchronizer. The FIFO uses the slave modport.
interface tx_resp_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 3
);
  logic                    WR_EN;
  logic [DATA_WIDTH-1:0]   WR_DATA;
  logic                    WR16_EN;
  logic [2*DATA_WIDTH-1:0] WR16_DATA;
  logic                    Busy;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic [ADDR_W:0]         COUNT;
  logic                    EMPTY;
  logic                    FULL;
  logic                    OVERFLOW;
  logic                    TX_TIMEOUT;

  modport master (
    output WR_EN, WR_DATA, WR16_EN, WR16_DATA, Busy,
    input  TX_P_DATA, TX_D_VLD, COUNT, EMPTY, FULL, OVERFLOW, TX_TIMEOUT
  );

  modport slave (
    input  WR_EN, WR_DATA, WR16_EN, WR16_DATA, Busy,
    output TX_P_DATA, TX_D_VLD, COUNT, EMPTY, FULL, OVERFLOW, TX_TIMEOUT
  );
endinterface

// File: rtl/tx_resp_fifo.sv
// Response byte queue in the REF_CLK domain; releases one byte per UART
// busy cycle as a single-cycle valid pulse toward the TX data synchronizer.
module tx_resp_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RST,
  tx_resp_fifo_if.slave bus
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LIM16    = (ADDR_W + 1)'(DEPTH - 2);
  localparam logic [TW-1:0]   TMAX     = TW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     rd_ptr, wr_ptr, wr_ptr_p1;
  logic [ADDR_W:0]       count, count_nxt, n_wr;
  logic [TW-1:0]         timer, timer_nxt;
  logic                  empty, full, overflow, tx_timeout, tx_d_vld;
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  pop, timeout_hit, wr1_ok, wr16_ok, drop;

  assign wr_ptr_p1 = wr_ptr + 1'b1;

  // Admission looks only at the registered COUNT; a same-cycle pop never makes room.
  always_comb begin
    wr16_ok   = bus.WR16_EN && (count <= LIM16);
    wr1_ok    = bus.WR_EN && !bus.WR16_EN && (count < CNT_FULL);
    drop      = (bus.WR16_EN && !wr16_ok) ||
                (bus.WR_EN && (bus.WR16_EN || (count == CNT_FULL)));
    n_wr      = wr16_ok ? (ADDR_W + 1)'(2) : (wr1_ok ? (ADDR_W + 1)'(1) : '0);
    count_nxt = count + n_wr - (ADDR_W + 1)'(pop);
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.Busy) begin
          pop       = 1'b1;
          timer_nxt = '0;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.Busy) begin
          state_nxt = WAIT_LO;
        end else if (timer == TMAX - 1'b1) begin
          timer_nxt   = TMAX;
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.Busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (wr16_ok) begin
        mem[wr_ptr]    <= bus.WR16_DATA[DATA_WIDTH-1:0];
        mem[wr_ptr_p1] <= bus.WR16_DATA[2*DATA_WIDTH-1:DATA_WIDTH];
      end else if (wr1_ok) begin
        mem[wr_ptr] <= bus.WR_DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      timer      <= '0;
      tx_p_data  <= '0;
      tx_d_vld   <= 1'b0;
      overflow   <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      count      <= count_nxt;
      empty      <= (count_nxt == '0);
      full       <= (count_nxt == CNT_FULL);
      timer      <= timer_nxt;
      tx_d_vld   <= pop;
      overflow   <= overflow | drop;
      tx_timeout <= tx_timeout | timeout_hit;
      if (pop) begin
        tx_p_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (wr16_ok)     wr_ptr <= wr_ptr + ADDR_W'(2);
      else if (wr1_ok) wr_ptr <= wr_ptr_p1;
    end
  end

  assign bus.TX_P_DATA  = tx_p_data;
  assign bus.TX_D_VLD   = tx_d_vld;
  assign bus.COUNT      = count;
  assign bus.EMPTY      = empty;
  assign bus.FULL       = full;
  assign bus.OVERFLOW   = overflow;
  assign bus.TX_TIMEOUT = tx_timeout;

endmodule

// File: tb/tb_tx_resp_fifo.sv
// Directed bench for tx_resp_fifo: reset, single byte, 16-bit ordering,
// full/wrap, WR16 corners, busy timeout and mid-send reset.
module tb_tx_resp_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   npulse;
  int   p0;

  tx_resp_fifo_if #(.DATA_WIDTH(8), .ADDR_W(3)) bus ();

  tx_resp_fifo #(
    .DATA_WIDTH  (8),
    .DEPTH       (8),
    .ADDR_W      (3),
    .BUSY_TIMEOUT(255)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.TX_D_VLD === 1'b1) npulse++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] d);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = d;
    tick();
    bus.WR_EN   = 1'b0;
  endtask

  // Pop one byte from IDLE, then run a minimal Busy rise/fall back to IDLE.
  task automatic drain_one(input logic [7:0] exp_d, input int exp_cnt);
    bus.Busy = 1'b0;
    tick();
    chk("drain_vld", {31'd0, bus.TX_D_VLD}, 32'd1);
    chk("drain_data", {24'd0, bus.TX_P_DATA}, {24'd0, exp_d});
    chk("drain_count", {28'd0, bus.COUNT}, exp_cnt);
    bus.Busy = 1'b1;
    tick();
    chk("drain_gap", {31'd0, bus.TX_D_VLD}, 32'd0);
    bus.Busy = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    npulse = 0;
    rst           = 1'b1;
    bus.WR_EN     = 1'b1;
    bus.WR_DATA   = 8'h55;
    bus.WR16_EN   = 1'b0;
    bus.WR16_DATA = '0;
    bus.Busy      = 1'b0;

    // Reset held two cycles with a write request present
    tick();
    tick();
    chk("rst_count", {28'd0, bus.COUNT}, 32'd0);
    chk("rst_empty", {31'd0, bus.EMPTY}, 32'd1);
    chk("rst_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
    chk("rst_ovf", {31'd0, bus.OVERFLOW}, 32'd0);
    chk("rst_tmo", {31'd0, bus.TX_TIMEOUT}, 32'd0);
    rst       = 1'b0;
    bus.WR_EN = 1'b0;
    tick();

    // Single byte; Busy rises 3 cycles after the pulse, falls 20 later
    p0 = npulse;
    wr_byte(8'hA5);
    chk("sb_count_w", {28'd0, bus.COUNT}, 32'd1);
    chk("sb_empty_w", {31'd0, bus.EMPTY}, 32'd0);
    chk("sb_vld_w", {31'd0, bus.TX_D_VLD}, 32'd0);
    tick();
    chk("sb_vld", {31'd0, bus.TX_D_VLD}, 32'd1);
    chk("sb_data", {24'd0, bus.TX_P_DATA}, 32'hA5);
    chk("sb_count", {28'd0, bus.COUNT}, 32'd0);
    tick();
    chk("sb_vld_once", {31'd0, bus.TX_D_VLD}, 32'd0);
    tick();
    tick();
    bus.Busy = 1'b1;
    repeat (20) tick();
    bus.Busy = 1'b0;
    tick();
    tick();
    chk("sb_pulses", npulse - p0, 32'd1);
    chk("sb_hold", {24'd0, bus.TX_P_DATA}, 32'hA5);
    chk("sb_empty", {31'd0, bus.EMPTY}, 32'd1);

    // 16-bit result goes out low byte first, high byte only after a busy cycle
    bus.WR16_EN   = 1'b1;
    bus.WR16_DATA = 16'h1234;
    tick();
    bus.WR16_EN = 1'b0;
    chk("w16_count", {28'd0, bus.COUNT}, 32'd2);
    tick();
    chk("w16_vld_lo", {31'd0, bus.TX_D_VLD}, 32'd1);
    chk("w16_lo", {24'd0, bus.TX_P_DATA}, 32'h34);
    p0 = npulse;
    repeat (3) tick();
    bus.Busy = 1'b1;
    tick();
    tick();
    chk("w16_wait", npulse - p0, 32'd1);
    bus.Busy = 1'b0;
    tick();
    chk("w16_idle_novld", {31'd0, bus.TX_D_VLD}, 32'd0);
    tick();
    chk("w16_vld_hi", {31'd0, bus.TX_D_VLD}, 32'd1);
    chk("w16_hi", {24'd0, bus.TX_P_DATA}, 32'h12);
    chk("w16_count0", {28'd0, bus.COUNT}, 32'd0);
    bus.Busy = 1'b1;
    tick();
    bus.Busy = 1'b0;
    tick();

    // Fill with Busy high, overflow on the ninth byte, then drain in order
    bus.Busy = 1'b1;
    for (int i = 0; i < 8; i++) wr_byte(8'(i));
    chk("full_count", {28'd0, bus.COUNT}, 32'd8);
    chk("full_flag", {31'd0, bus.FULL}, 32'd1);
    chk("full_noovf", {31'd0, bus.OVERFLOW}, 32'd0);
    wr_byte(8'hFF);
    chk("full_ovf", {31'd0, bus.OVERFLOW}, 32'd1);
    chk("full_count9", {28'd0, bus.COUNT}, 32'd8);
    for (int i = 0; i < 8; i++) drain_one(8'(i), 7 - i);
    chk("full_drained", {31'd0, bus.EMPTY}, 32'd1);

    // Two batches that walk the pointers across the wrap
    bus.Busy = 1'b1;
    for (int i = 0; i < 5; i++) wr_byte(8'(8'h10 + i));
    chk("wrap_b1_count", {28'd0, bus.COUNT}, 32'd5);
    for (int i = 0; i < 5; i++) drain_one(8'(8'h10 + i), 4 - i);
    bus.Busy = 1'b1;
    for (int i = 0; i < 7; i++) wr_byte(8'(8'h15 + i));
    chk("wrap_b2_count", {28'd0, bus.COUNT}, 32'd7);
    for (int i = 0; i < 7; i++) drain_one(8'(8'h15 + i), 6 - i);

    // WR16 rejected at COUNT=7
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c16_rst_ovf", {31'd0, bus.OVERFLOW}, 32'd0);
    bus.Busy = 1'b1;
    for (int i = 0; i < 7; i++) wr_byte(8'(8'h20 + i));
    bus.WR16_EN   = 1'b1;
    bus.WR16_DATA = 16'hABCD;
    tick();
    bus.WR16_EN = 1'b0;
    chk("c16_count7", {28'd0, bus.COUNT}, 32'd7);
    chk("c16_notfull", {31'd0, bus.FULL}, 32'd0);
    chk("c16_ovf", {31'd0, bus.OVERFLOW}, 32'd1);

    // WR_EN and WR16_EN together on an empty FIFO: only the 16-bit pair lands
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.Busy      = 1'b1;
    bus.WR_EN     = 1'b1;
    bus.WR_DATA   = 8'h77;
    bus.WR16_EN   = 1'b1;
    bus.WR16_DATA = 16'h5566;
    tick();
    bus.WR_EN   = 1'b0;
    bus.WR16_EN = 1'b0;
    chk("both_count", {28'd0, bus.COUNT}, 32'd2);
    chk("both_ovf", {31'd0, bus.OVERFLOW}, 32'd1);
    drain_one(8'h66, 1);
    drain_one(8'h55, 0);

    // Busy never rises: timeout exactly 255 cycles after the send
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_byte(8'h9C);
    tick();
    chk("tmo_vld", {31'd0, bus.TX_D_VLD}, 32'd1);
    chk("tmo_data", {24'd0, bus.TX_P_DATA}, 32'h9C);
    repeat (254) tick();
    chk("tmo_early", {31'd0, bus.TX_TIMEOUT}, 32'd0);
    tick();
    chk("tmo_set", {31'd0, bus.TX_TIMEOUT}, 32'd1);
    wr_byte(8'h3C);
    tick();
    chk("tmo_idle_vld", {31'd0, bus.TX_D_VLD}, 32'd1);
    chk("tmo_idle_data", {24'd0, bus.TX_P_DATA}, 32'h3C);

    // Reset in WAIT_LO with three entries queued
    bus.Busy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) wr_byte(8'(8'h40 + i));
    chk("mrst_count3", {28'd0, bus.COUNT}, 32'd3);
    chk("mrst_novld", {31'd0, bus.TX_D_VLD}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_count", {28'd0, bus.COUNT}, 32'd0);
    chk("mrst_empty", {31'd0, bus.EMPTY}, 32'd1);
    chk("mrst_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
    chk("mrst_tmo", {31'd0, bus.TX_TIMEOUT}, 32'd0);
    chk("mrst_data", {24'd0, bus.TX_P_DATA}, 32'd0);
    bus.Busy = 1'b0;
    p0 = npulse;
    repeat (10) tick();
    chk("mrst_nopulse", npulse - p0, 32'd0);
    chk("mrst_count_end", {28'd0, bus.COUNT}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
